// File: rtl/irq_arb_pkg.sv
// Shared types and constants for the eight-input interrupt arbiter.
// Imported by the priority encoder and the arbiter top level.
package irq_arb_pkg;

    localparam int unsigned NUM_REQ         = 8;
    localparam int unsigned VEC_W           = 3;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] vec2onehot(input logic [VEC_W-1:0] v);
        logic [NUM_REQ-1:0] oh;
        oh    = '0;
        oh[v] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder, highest set index wins.
// Active-high I/O; hit_o flags that at least one input is set.
module prio_enc8
    import irq_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    output logic [VEC_W-1:0]   idx_o,
    output logic               hit_o
);

    always_comb begin
        idx_o = '0;
        // Ascending scan: the last set bit seen is the highest index.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_i[i]) begin
                idx_o = VEC_W'(i);
            end
        end
    end

    assign hit_o = |req_i;

endmodule

// File: rtl/irq_arbiter8.sv
// Eight-input interrupt arbiter: synchronises active-low requests, latches falling edges
// as pending bits and serves one masked winner at a time over an irq/ack/eoi handshake.
module irq_arbiter8
    import irq_arb_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_n,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               en_n,
    input  logic               ack,
    input  logic               eoi,
    output logic               irq,
    output logic [VEC_W-1:0]   vec,
    output logic               busy,
    output logic               gs_n,
    output logic [NUM_REQ-1:0] pending
);

    logic [SYNC_STAGES-1:0][NUM_REQ-1:0] sync_q, sync_d;
    logic [NUM_REQ-1:0]                  hist_q, hist_d;
    logic [NUM_REQ-1:0]                  pending_q, pending_d;
    logic [NUM_REQ-1:0]                  fall;
    logic [NUM_REQ-1:0]                  cand;
    logic [NUM_REQ-1:0]                  clr;
    logic [VEC_W-1:0]                    win;
    logic                                hit;
    arb_state_e                          state_q, state_d;
    logic [VEC_W-1:0]                    vec_q, vec_d;
    logic                                irq_q, irq_d;
    logic                                busy_q, busy_d;
    logic                                gs_n_q, gs_n_d;

    // Synchroniser chain plus one history stage for edge detection.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_n};
        hist_d = sync_q[SYNC_STAGES-1];
        fall   = hist_q & ~sync_q[SYNC_STAGES-1];
    end

    assign cand = pending_q & ~mask;

    prio_enc8 u_prio_enc8 (
        .req_i (cand),
        .idx_o (win),
        .hit_o (hit)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        clr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (!en_n && hit) begin
                    state_d = ST_REQ;
                    vec_d   = win;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_d = ST_SERV;
                    clr     = vec2onehot(vec_q);
                end else if (en_n || !hit) begin
                    state_d = ST_IDLE;
                end else begin
                    // Re-offer every cycle so a higher-priority arrival preempts.
                    vec_d = win;
                end
            end
            ST_SERV: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh falling edge overrides a same-cycle acknowledge clear.
        pending_d = (pending_q & ~clr) | fall;
        irq_d     = (state_d == ST_REQ);
        busy_d    = (state_d == ST_SERV);
        gs_n_d    = ~(hit & ~en_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            hist_q    <= '1;
            pending_q <= '0;
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            gs_n_q    <= 1'b1;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            vec_q     <= vec_d;
            irq_q     <= irq_d;
            busy_q    <= busy_d;
            gs_n_q    <= gs_n_d;
        end
    end

    assign irq     = irq_q;
    assign vec     = vec_q;
    assign busy    = busy_q;
    assign gs_n    = gs_n_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_arbiter8.sv
// Directed and randomised checks of irq_arbiter8 against a cycle-level behavioural model
// built from a sample-history queue and the handshake rules.
module tb_irq_arbiter8;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_n;
    logic [7:0] mask;
    logic       en_n;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [2:0] vec;
    logic       busy;
    logic       gs_n;
    logic [7:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [7:0] samp[$];
    logic [7:0] m_pend;
    logic       m_offer;
    logic       m_serv;
    logic [2:0] m_vec;
    logic       m_gs_n;

    irq_arbiter8 #(.SYNC_STAGES(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_n   (req_n),
        .mask    (mask),
        .en_n    (en_n),
        .ack     (ack),
        .eoi     (eoi),
        .irq     (irq),
        .vec     (vec),
        .busy    (busy),
        .gs_n    (gs_n),
        .pending (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        for (int i = 0; i < S + 2; i++) samp.push_front(8'hFF);
        m_pend  = '0;
        m_offer = 1'b0;
        m_serv  = 1'b0;
        m_vec   = '0;
        m_gs_n  = 1'b1;
    endtask

    task automatic check_model(input string ctx);
        chk({ctx, ".irq"},     {7'd0, irq},  {7'd0, m_offer});
        chk({ctx, ".vec"},     {5'd0, vec},  {5'd0, m_vec});
        chk({ctx, ".busy"},    {7'd0, busy}, {7'd0, m_serv});
        chk({ctx, ".gs_n"},    {7'd0, gs_n}, {7'd0, m_gs_n});
        chk({ctx, ".pending"}, pending,      m_pend);
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step(input string ctx);
        logic [7:0] cand, clrm, fall;
        int         win;
        bit         hit;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            samp.push_front(req_n);
            if (samp.size() > S + 2) void'(samp.pop_back());
            fall = samp[S+1] & ~samp[S];
            cand = m_pend & ~mask;
            hit  = (cand != 8'd0);
            win  = 0;
            for (int i = 0; i < 8; i++) if (cand[i]) win = i;
            clrm = '0;
            if (m_serv) begin
                if (eoi) m_serv = 1'b0;
            end else if (m_offer) begin
                if (ack) begin
                    clrm    = 8'd1 << m_vec;
                    m_offer = 1'b0;
                    m_serv  = 1'b1;
                end else if (en_n || !hit) begin
                    m_offer = 1'b0;
                end else begin
                    m_vec = win[2:0];
                end
            end else if (!en_n && hit) begin
                m_offer = 1'b1;
                m_vec   = win[2:0];
            end
            m_pend = (m_pend & ~clrm) | fall;
            m_gs_n = !(hit && !en_n);
        end
        #1;
        check_model(ctx);
    endtask

    task automatic steps(input int n, input string ctx);
        for (int i = 0; i < n; i++) step(ctx);
    endtask

    task automatic pulse_ack(input string ctx);
        ack = 1'b1;
        step(ctx);
        ack = 1'b0;
    endtask

    task automatic pulse_eoi(input string ctx);
        eoi = 1'b1;
        step(ctx);
        eoi = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req_n = 8'hFF;
        mask  = 8'h00;
        en_n  = 1'b0;
        ack   = 1'b0;
        eoi   = 1'b0;
        model_reset();
        #1;
        check_model("reset_async");
        steps(3, "reset_hold");
        rst = 1'b0;

        // Single request on bit 2
        req_n[2] = 1'b0;
        steps(3, "single");
        chk("single.pending_e3", pending, 8'h04);
        step("single");
        chk("single.irq_e4", {7'd0, irq}, 8'd1);
        chk("single.vec_e4", {5'd0, vec}, 8'd2);
        chk("single.gs_n_e4", {7'd0, gs_n}, 8'd0);
        pulse_ack("single_ack");
        chk("single.ack_irq", {7'd0, irq}, 8'd0);
        chk("single.ack_busy", {7'd0, busy}, 8'd1);
        chk("single.ack_pending", pending, 8'h00);
        pulse_eoi("single_eoi");
        chk("single.eoi_busy", {7'd0, busy}, 8'd0);
        req_n = 8'hFF;
        steps(3, "single_tail");

        // Priority: bits 1 and 6 together
        req_n = ~8'h42;
        steps(4, "prio");
        chk("prio.first_vec", {5'd0, vec}, 8'd6);
        chk("prio.first_irq", {7'd0, irq}, 8'd1);
        pulse_ack("prio_ack");
        pulse_eoi("prio_eoi");
        chk("prio.gap_irq", {7'd0, irq}, 8'd0);
        step("prio_reoffer");
        chk("prio.second_irq", {7'd0, irq}, 8'd1);
        chk("prio.second_vec", {5'd0, vec}, 8'd1);
        pulse_ack("prio_ack2");
        pulse_eoi("prio_eoi2");
        req_n = 8'hFF;
        steps(3, "prio_tail");

        // Preemption of an un-acked offer
        req_n[3] = 1'b0;
        steps(4, "preempt");
        chk("preempt.vec3", {5'd0, vec}, 8'd3);
        req_n[7] = 1'b0;
        steps(3, "preempt");
        chk("preempt.still3", {5'd0, vec}, 8'd3);
        step("preempt");
        chk("preempt.vec7", {5'd0, vec}, 8'd7);
        chk("preempt.irq_held", {7'd0, irq}, 8'd1);
        pulse_ack("preempt_ack");
        chk("preempt.pending_left", pending, 8'h08);
        pulse_eoi("preempt_eoi");
        step("preempt_reoffer");
        chk("preempt.reoffer3", {5'd0, vec}, 8'd3);
        pulse_ack("preempt_ack2");
        pulse_eoi("preempt_eoi2");
        req_n = 8'hFF;
        steps(3, "preempt_tail");

        // Mask and enable
        mask     = 8'h10;
        req_n[4] = 1'b0;
        steps(4, "mask");
        chk("mask.pending", pending, 8'h10);
        chk("mask.irq", {7'd0, irq}, 8'd0);
        chk("mask.gs_n", {7'd0, gs_n}, 8'd1);
        mask = 8'h00;
        step("unmask");
        chk("unmask.irq", {7'd0, irq}, 8'd1);
        chk("unmask.vec", {5'd0, vec}, 8'd4);
        en_n = 1'b1;
        step("disable");
        chk("disable.irq", {7'd0, irq}, 8'd0);
        chk("disable.pending", pending, 8'h10);
        en_n = 1'b0;
        step("reenable");
        pulse_ack("mask_ack");
        pulse_eoi("mask_eoi");
        req_n = 8'hFF;
        steps(3, "mask_tail");

        // Ignored handshakes
        pulse_ack("idle_ack");
        chk("idle_ack.busy", {7'd0, busy}, 8'd0);
        chk("idle_ack.irq", {7'd0, irq}, 8'd0);
        req_n[0] = 1'b0;
        steps(4, "req_eoi");
        pulse_eoi("req_eoi");
        chk("req_eoi.irq", {7'd0, irq}, 8'd1);
        chk("req_eoi.busy", {7'd0, busy}, 8'd0);

        // Falling edge on bit 5 coinciding with its acknowledge
        req_n[5] = 1'b0;
        step("setclr");
        req_n[5] = 1'b1;
        step("setclr");
        req_n[5] = 1'b0;
        steps(2, "setclr");
        chk("setclr.vec5", {5'd0, vec}, 8'd5);
        pulse_ack("setclr_ack");
        chk("setclr.pending5", {7'd0, pending[5]}, 8'd1);
        chk("setclr.busy", {7'd0, busy}, 8'd1);

        // Asynchronous reset while in service
        #2;
        rst   = 1'b1;
        req_n = 8'hFF;
        #1;
        model_reset();
        check_model("rst_serv");
        steps(2, "rst_serv_hold");
        rst = 1'b0;
        steps(2, "rst_serv_after");

        // Randomised traffic
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) req_n[b] = ~req_n[b];
            end
            if ($urandom_range(15) == 0) mask = ($urandom_range(2) == 0) ? 8'($urandom) : 8'h00;
            en_n = ($urandom_range(9) == 0);
            ack  = ($urandom_range(3) == 0);
            eoi  = ($urandom_range(4) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
